irq_counter_bank: RTL and testbench

Parametrised multi-channel interrupt counter and controller between external interrupt sources and the PicoRV32 core. Replaces the single-line `irq`/`irq_counter` arrangement of the current system. Each channel synchronises its input, detects rising edges, counts them (wrap or saturate), and latches a pending flag. Masked pending flags drive the CPU interrupt vector. All state is readable and clearable over the native memory bus.

---
 rtl/irq_bank_pkg.sv | 17 +
 rtl/irq_sync_edge.sv | 32 +++
 rtl/irq_counter_bank.sv | 160 ++++++++++++++++
 tb/tb_irq_counter_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_bank_pkg.sv
// Shared definitions for the interrupt counter bank:
// register offsets and bus handshake states.
package irq_bank_pkg;

    localparam logic [7:0] REG_ENABLE     = 8'h00;
    localparam logic [7:0] REG_SATMODE    = 8'h04;
    localparam logic [7:0] REG_PENDING    = 8'h08;
    localparam logic [7:0] REG_MASK       = 8'h0C;
    localparam logic [7:0] REG_OVF        = 8'h10;
    localparam logic [7:0] REG_COUNT_BASE = 8'h20;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line
// with a one-cycle rising-edge strobe on the synchronised value.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_in,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_counter_bank.sv
// Multi-channel interrupt edge counter with pending/mask/overflow
// state, exposed on the native memory bus.
module irq_counter_bank
    import irq_bank_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] irq_in,
    output logic [NUM_CH-1:0] irq_out,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [7:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_rdata
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int CNT_WORD = int'(REG_COUNT_BASE >> 2);

    bus_state_e state_q, state_d;
    logic [31:0] rdata_q, rdata_d, rd_val;

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] sat_q, sat_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];

    logic [NUM_CH-1:0] edge_raw, hit, wrap, cnt_clr, pend_clr, ovf_clr;
    logic [5:0] word;
    logic accept, we;
    logic unused_bits;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .resetn(resetn),
            .d_in  (irq_in[g]),
            .edge_o(edge_raw[g])
        );
    end

    function automatic logic [NUM_CH-1:0] merge(
        input logic [NUM_CH-1:0] old_v,
        input logic [NUM_CH-1:0] wd,
        input logic [3:0]        strb
    );
        for (int j = 0; j < NUM_CH; j++)
            merge[j] = strb[j/8] ? wd[j] : old_v[j];
    endfunction

    assign hit         = edge_raw & en_q;
    assign word        = bus_addr[7:2];
    assign accept      = (state_q == BUS_IDLE) && bus_valid;
    assign we          = accept && (|bus_wstrb);
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    always_comb begin
        rd_val = '0;
        case (word)
            REG_ENABLE[7:2]:  rd_val[NUM_CH-1:0] = en_q;
            REG_SATMODE[7:2]: rd_val[NUM_CH-1:0] = sat_q;
            REG_PENDING[7:2]: rd_val[NUM_CH-1:0] = pend_q;
            REG_MASK[7:2]:    rd_val[NUM_CH-1:0] = mask_q;
            REG_OVF[7:2]:     rd_val[NUM_CH-1:0] = ovf_q;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++)
            if (int'(word) == CNT_WORD + i) rd_val[CNT_WIDTH-1:0] = cnt_q[i];
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            BUS_IDLE: if (bus_valid) begin
                state_d = BUS_ACK;
                rdata_d = rd_val;
            end
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        sat_d    = sat_q;
        mask_d   = mask_q;
        pend_clr = '0;
        ovf_clr  = '0;
        cnt_clr  = '0;
        wrap     = '0;
        if (we) begin
            case (word)
                REG_ENABLE[7:2]:  en_d = merge(en_q, bus_wdata[NUM_CH-1:0], bus_wstrb);
                REG_SATMODE[7:2]: sat_d = merge(sat_q, bus_wdata[NUM_CH-1:0], bus_wstrb);
                REG_MASK[7:2]:    mask_d = merge(mask_q, bus_wdata[NUM_CH-1:0], bus_wstrb);
                REG_PENDING[7:2]: pend_clr = bus_wdata[NUM_CH-1:0];
                REG_OVF[7:2]:     ovf_clr = bus_wdata[NUM_CH-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++)
                cnt_clr[i] = (int'(word) == CNT_WORD + i);
        end
        // A clear racing an edge leaves exactly the new edge counted.
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr[i]) begin
                cnt_d[i] = hit[i] ? CNT_WIDTH'(1) : '0;
            end else if (hit[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (!sat_q[i]) begin
                    cnt_d[i] = '0;
                    wrap[i]  = 1'b1;
                end
            end
        end
        pend_d = (pend_q & ~pend_clr) | hit;
        ovf_d  = (ovf_q & ~ovf_clr) | wrap;
        irq_d  = pend_q & mask_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= BUS_IDLE;
            rdata_q <= '0;
            en_q    <= '0;
            sat_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            ovf_q   <= '0;
            irq_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            sat_q   <= sat_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign irq_out   = irq_q;
    assign bus_ready = (state_q == BUS_ACK);
    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_irq_counter_bank.sv
// Directed self-checking bench for irq_counter_bank
// (4 channels, 4-bit counters, 2 sync stages).
module tb_irq_counter_bank;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  irq_in = '0;
    logic [3:0]  irq_out;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [3:0]  bus_wstrb = '0;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad = 0;

    irq_counter_bank #(
        .NUM_CH(4), .CNT_WIDTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .irq_in(irq_in), .irq_out(irq_out),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic bus_xfer(input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output logic [31:0] rdv);
        bit got = 0;
        rdv = '0;
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = a; bus_wdata = wd; bus_wstrb = ws;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk); #1;
            if (bus_ready) begin got = 1; rdv = bus_rdata; end
        end
        @(negedge clk);
        bus_valid = 1'b0; bus_wstrb = '0;
        total++;
        if (!got) begin bad++; $display("FAIL bus_timeout addr=%h", a); end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, d, 4'hF, dummy);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
        bus_xfer(a, 32'h0, 4'h0, v);
    endtask

    task automatic pulse(input int ch, input int hi);
        @(negedge clk);
        irq_in[ch] = 1'b1;
        repeat (hi) @(negedge clk);
        irq_in[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [7:0] addrs [9];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C};
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wr_reg(8'h00, 32'hF);
        wr_reg(8'h0C, 32'h5);
        wr_reg(8'h04, 32'h3);
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 8'h00; bus_wstrb = 4'h0;
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus_ready); end
        total++; if (bus_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus_rdata); end
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL rst_irq_out got=%h exp=0", irq_out); end
        @(negedge clk);
        bus_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_hold got=%b exp=0", bus_ready); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rd_reg(addrs[i], v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_reg addr=%h got=%h exp=0", addrs[i], v); end
        end
    endtask

    task automatic test_basic_count;
        logic [31:0] v;
        wr_reg(8'h00, 32'hF);
        wr_reg(8'h0C, 32'h1);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        total++; if (irq_out[0] !== 1'b0) begin bad++; $display("FAIL lat_k2 got=%b exp=0", irq_out[0]); end
        @(posedge clk); #1;
        total++; if (irq_out[0] !== 1'b1) begin bad++; $display("FAIL lat_k3 got=%b exp=1", irq_out[0]); end
        @(negedge clk);
        irq_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) pulse(0, 3);
        rd_reg(8'h20, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL count0 got=%0d exp=5", v); end
        rd_reg(8'h08, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL pend0 got=%h exp=1", v); end
        wr_reg(8'h08, 32'h1);
        @(posedge clk); #1;
        total++; if (irq_out[0] !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=0", irq_out[0]); end
        rd_reg(8'h08, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL pend_clr got=%h exp=0", v); end
    endtask

    task automatic test_sat_wrap;
        logic [31:0] v;
        wr_reg(8'h04, 32'h2);
        repeat (17) pulse(1, 2);
        rd_reg(8'h24, v);
        total++; if (v !== 32'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", v); end
        rd_reg(8'h10, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL sat_ovf got=%h exp=0", v); end
        bus_xfer(8'h04, 32'h0, 4'b0010, v);
        rd_reg(8'h04, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL strobe_sat got=%h exp=2", v); end
        wr_reg(8'h24, 32'h0);
        rd_reg(8'h24, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL cnt_clr1 got=%0d exp=0", v); end
        wr_reg(8'h04, 32'h0);
        repeat (17) pulse(1, 2);
        rd_reg(8'h24, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", v); end
        rd_reg(8'h10, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL wrap_ovf got=%h exp=2", v); end
        bus_xfer(8'h10, 32'h2, 4'b1000, v);
        rd_reg(8'h10, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ovf_w1c got=%h exp=0", v); end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        logic [7:0] ca [2];
        ca = '{8'h08, 8'h28};
        wr_reg(8'h08, 32'hF);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            irq_in[2] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            bus_valid = 1'b1; bus_addr = ca[t]; bus_wdata = 32'h4; bus_wstrb = 4'hF;
            @(posedge clk); #1;
            total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL coll_ack%0d got=%b exp=1", t, bus_ready); end
            @(negedge clk);
            bus_valid = 1'b0; bus_wstrb = 4'h0; irq_in[2] = 1'b0;
            repeat (3) @(negedge clk);
        end
        rd_reg(8'h08, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL coll_pend got=%h exp=4", v); end
        rd_reg(8'h28, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL coll_count got=%0d exp=1", v); end
        wr_reg(8'h28, 32'h0);
        rd_reg(8'h28, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL cnt_clr2 got=%0d exp=0", v); end
    endtask

    task automatic test_disable_mask;
        logic [31:0] v;
        wr_reg(8'h00, 32'h0);
        wr_reg(8'h08, 32'hF);
        repeat (4) pulse(3, 2);
        rd_reg(8'h2C, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL dis_count got=%0d exp=0", v); end
        rd_reg(8'h08, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL dis_pend got=%h exp=0", v); end
        wr_reg(8'h00, 32'h8);
        wr_reg(8'h0C, 32'h0);
        pulse(3, 2);
        rd_reg(8'h08, v);
        total++; if (v !== 32'h8) begin bad++; $display("FAIL mask_pend got=%h exp=8", v); end
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL mask_irq got=%h exp=0", irq_out); end
        rd_reg(8'h2C, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL en_count got=%0d exp=1", v); end
    endtask

    task automatic test_bus;
        logic exp_r;
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 8'h40; bus_wstrb = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_r = (i % 2 == 0);
            total++; if (bus_ready !== exp_r) begin bad++; $display("FAIL ready_seq i=%0d got=%b exp=%b", i, bus_ready, exp_r); end
            if (exp_r) begin
                total++; if (bus_rdata !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", bus_rdata); end
            end
        end
        @(negedge clk);
        bus_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_sat_wrap();
        test_collision();
        test_disable_mask();
        test_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
